// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline control logic: forwarding selects,
// hazard FSM states and the hard-wired zero register index.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN  = 1'b0,
      BUSY = 1'b1
   } hazard_state_t;

   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: stage register indices and control bits in,
// stall/flush/forward controls and perf counters out.
interface hazard_ctrl_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
);
   import pipeline_pkg::*;

   logic [REG_ADDR_WIDTH-1:0] rs1D_i, rs2D_i;
   logic [REG_ADDR_WIDTH-1:0] rs1E_i, rs2E_i;
   logic [REG_ADDR_WIDTH-1:0] rdE_i, rdM_i, rdW_i;
   logic                      reg_writeM_i, reg_writeW_i;
   logic                      loadE_i, pc_srcE_i;
   logic                      mdu_startE_i, mdu_done_i;

   logic                      stallF_o, stallD_o, stallE_o;
   logic                      flushD_o, flushE_o, flushM_o;
   fwd_sel_t                  forward_aE_o, forward_bE_o;
   logic                      mdu_timeout_o;
   logic [CNT_WIDTH-1:0]      stall_cnt_o, flush_cnt_o;

   // Datapath side.
   modport master (
      output rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i,
             reg_writeM_i, reg_writeW_i, loadE_i, pc_srcE_i,
             mdu_startE_i, mdu_done_i,
      input  stallF_o, stallD_o, stallE_o, flushD_o, flushE_o, flushM_o,
             forward_aE_o, forward_bE_o, mdu_timeout_o,
             stall_cnt_o, flush_cnt_o
   );

   // Hazard-unit side.
   modport slave (
      input  rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i,
             reg_writeM_i, reg_writeW_i, loadE_i, pc_srcE_i,
             mdu_startE_i, mdu_done_i,
      output stallF_o, stallD_o, stallE_o, flushD_o, flushE_o, flushM_o,
             forward_aE_o, forward_bE_o, mdu_timeout_o,
             stall_cnt_o, flush_cnt_o
   );

endinterface

// File: rtl/forward_unit.sv
// Per-operand bypass select: the M-stage ALU result wins over the
// W-stage result; writes to the zero register are never forwarded.
module forward_unit
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
   input  logic                      reg_write_m_i,
   input  logic                      reg_write_w_i,
   output fwd_sel_t                  sel_o
);

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO = REG_ADDR_WIDTH'(REG_ZERO);

   always_comb begin
      // NOTE: default assignment first so no path leaves sel_o unassigned (no latch).
      sel_o = FWD_NONE;
      if (reg_write_m_i && (rd_m_i != ZERO) && (rd_m_i == rs_e_i)) begin
         sel_o = FWD_MEM;
      end else if (reg_write_w_i && (rd_w_i != ZERO) && (rd_w_i == rs_e_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall, redirect flush and
// the MDU wait FSM with watchdog. Perf counters exist only with HAZARD_PERF_EN.
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MDU_TIMEOUT    = 64,
   parameter int CNT_WIDTH      = 32
) (
   input logic           clk_i,
   input logic           rst_i,
   hazard_ctrl_if.slave  hif
);

   localparam int                  WD_WIDTH = $clog2(MDU_TIMEOUT);
   localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'(MDU_TIMEOUT - 1);
   localparam logic [REG_ADDR_WIDTH-1:0] ZERO = REG_ADDR_WIDTH'(REG_ZERO);

   hazard_state_t        state_q, state_d;
   logic [WD_WIDTH-1:0]  wd_cnt_q, wd_cnt_d;
   logic                 timeout_q, timeout_d;

   fwd_sel_t fwd_a, fwd_b;
   logic     busy, wd_hit, mdu_release, mdu_stall, lw_raw, lw_stall, redirect;

   forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
      .rs_e_i(hif.rs1E_i), .rd_m_i(hif.rdM_i), .rd_w_i(hif.rdW_i),
      .reg_write_m_i(hif.reg_writeM_i), .reg_write_w_i(hif.reg_writeW_i),
      .sel_o(fwd_a)
   );

   forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
      .rs_e_i(hif.rs2E_i), .rd_m_i(hif.rdM_i), .rd_w_i(hif.rdW_i),
      .reg_write_m_i(hif.reg_writeM_i), .reg_write_w_i(hif.reg_writeW_i),
      .sel_o(fwd_b)
   );

   // While BUSY the E stage is frozen, so redirect and start are ignored.
   always_comb begin
      busy        = (state_q == BUSY);
      wd_hit      = busy && (wd_cnt_q == WD_LAST);
      mdu_release = hif.mdu_done_i || wd_hit;
      lw_raw      = hif.loadE_i && (hif.rdE_i != ZERO) &&
                    ((hif.rdE_i == hif.rs1D_i) || (hif.rdE_i == hif.rs2D_i));
      redirect    = !rst_i && !busy && hif.pc_srcE_i;
      lw_stall    = !rst_i && !busy && !hif.pc_srcE_i && lw_raw;
      mdu_stall   = !rst_i && (busy ? !mdu_release
                                    : (hif.mdu_startE_i && !hif.pc_srcE_i && !hif.mdu_done_i));
   end

   always_comb begin
      state_d   = state_q;
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q || (wd_hit && !hif.mdu_done_i);
      if (!busy) begin
         if (hif.mdu_startE_i && !hif.pc_srcE_i && !hif.mdu_done_i) begin
            state_d  = BUSY;
            wd_cnt_d = '0;
         end
      end else if (mdu_release) begin
         state_d  = RUN;
         wd_cnt_d = '0;
      end else begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         state_q   <= RUN;
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign hif.stallF_o      = mdu_stall || lw_stall;
   assign hif.stallD_o      = mdu_stall || lw_stall;
   assign hif.stallE_o      = mdu_stall;
   assign hif.flushD_o      = rst_i || redirect;
   assign hif.flushE_o      = rst_i || redirect || (lw_stall && !mdu_stall);
   assign hif.flushM_o      = rst_i || mdu_stall;
   assign hif.forward_aE_o  = rst_i ? FWD_NONE : fwd_a;
   assign hif.forward_bE_o  = rst_i ? FWD_NONE : fwd_b;
   assign hif.mdu_timeout_o = timeout_q;

`ifdef HAZARD_PERF_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   // Saturating event counters; reset holds them at zero.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hif.stallF_o && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
      if ((hif.flushD_o || hif.flushE_o) && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hif.stall_cnt_o = stall_cnt_q;
   assign hif.flush_cnt_o = flush_cnt_q;
`else
   assign hif.stall_cnt_o = {CNT_WIDTH{1'b0}};
   assign hif.flush_cnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_TIMEOUT=8): reset, forwarding,
// load-use, redirect, MDU wait, watchdog, async reset and perf counters.
module tb_hazard_ctrl;
   import pipeline_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) hif ();

   hazard_ctrl #(.REG_ADDR_WIDTH(5), .MDU_TIMEOUT(8), .CNT_WIDTH(32)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .hif  (hif)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      hif.rs1D_i = '0; hif.rs2D_i = '0; hif.rs1E_i = '0; hif.rs2E_i = '0;
      hif.rdE_i  = '0; hif.rdM_i  = '0; hif.rdW_i  = '0;
      hif.reg_writeM_i = 1'b0; hif.reg_writeW_i = 1'b0;
      hif.loadE_i = 1'b0; hif.pc_srcE_i = 1'b0;
      hif.mdu_startE_i = 1'b0; hif.mdu_done_i = 1'b0;
   endtask

   // Packs stallF,stallD,stallE,flushD,flushE,flushM.
   function automatic logic [5:0] ctl();
      return {hif.stallF_o, hif.stallD_o, hif.stallE_o,
              hif.flushD_o, hif.flushE_o, hif.flushM_o};
   endfunction

   initial begin
      idle_inputs();
      // Reset held for three cycles with a forwarding match present.
      hif.rdM_i = 5'd5; hif.rs1E_i = 5'd5; hif.reg_writeM_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ctl",     {26'd0, ctl()}, 32'b000_111);
      check("rst_timeout", {31'd0, hif.mdu_timeout_o}, 32'd0);
      check("rst_fwd_a",   {30'd0, hif.forward_aE_o}, 32'd0);

      @(negedge clk); rst = 1'b0;
      // Forwarding: M has priority over W.
      hif.rdW_i = 5'd5; hif.reg_writeW_i = 1'b1; hif.rs2E_i = 5'd3;
      #1;
      check("fwd_mem_a",   {30'd0, hif.forward_aE_o}, 32'b10);
      check("fwd_none_b",  {30'd0, hif.forward_bE_o}, 32'b00);
      check("idle_ctl",    {26'd0, ctl()}, 32'd0);
      @(negedge clk); hif.reg_writeM_i = 1'b0; hif.rs2E_i = 5'd5; #1;
      check("fwd_wb_a",    {30'd0, hif.forward_aE_o}, 32'b01);
      check("fwd_wb_b",    {30'd0, hif.forward_bE_o}, 32'b01);
      @(negedge clk);
      hif.reg_writeM_i = 1'b1; hif.rdM_i = '0; hif.rdW_i = '0;
      hif.rs1E_i = '0; hif.rs2E_i = '0; #1;
      check("fwd_zero_a",  {30'd0, hif.forward_aE_o}, 32'b00);
      check("fwd_zero_b",  {30'd0, hif.forward_bE_o}, 32'b00);

      // Load-use, then load-use plus redirect, then rdE=0.
      @(negedge clk); idle_inputs();
      hif.loadE_i = 1'b1; hif.rdE_i = 5'd7; hif.rs2D_i = 5'd7; #1;
      check("lw_ctl",      {26'd0, ctl()}, 32'b110_010);
      @(negedge clk); hif.pc_srcE_i = 1'b1; #1;
      check("lw_redir",    {26'd0, ctl()}, 32'b000_110);
      @(negedge clk); hif.pc_srcE_i = 1'b0; hif.rdE_i = '0; hif.rs2D_i = '0; #1;
      check("lw_rd0",      {26'd0, ctl()}, 32'd0);

      // MDU: start in cycle 0, done in cycle 4; redirect ignored while BUSY.
      @(negedge clk); idle_inputs(); hif.mdu_startE_i = 1'b1; #1;
      check("mdu_c0",      {26'd0, ctl()}, 32'b111_001);
      @(negedge clk); hif.mdu_startE_i = 1'b0; #1;
      check("mdu_c1",      {26'd0, ctl()}, 32'b111_001);
      @(negedge clk); hif.pc_srcE_i = 1'b1; #1;
      check("mdu_c2_redir",{26'd0, ctl()}, 32'b111_001);
      @(negedge clk); hif.pc_srcE_i = 1'b0; #1;
      check("mdu_c3",      {26'd0, ctl()}, 32'b111_001);
      @(negedge clk); hif.mdu_done_i = 1'b1; #1;
      check("mdu_c4_done", {26'd0, ctl()}, 32'd0);
      @(negedge clk); hif.mdu_done_i = 1'b0; #1;
      check("mdu_c5_run",  {26'd0, ctl()}, 32'd0);

      // Start with done in the same cycle never stalls.
      @(negedge clk); hif.mdu_startE_i = 1'b1; hif.mdu_done_i = 1'b1; #1;
      check("mdu_fast",    {26'd0, ctl()}, 32'd0);
      @(negedge clk); idle_inputs(); #1;
      check("mdu_fast_nxt",{26'd0, ctl()}, 32'd0);

      // Watchdog: start, BUSY cycles 0..6 stall, released at BUSY cycle 7.
      @(negedge clk); hif.mdu_startE_i = 1'b1; #1;
      check("wd_start",    {31'd0, hif.stallF_o}, 32'd1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); hif.mdu_startE_i = 1'b0; #1;
         check($sformatf("wd_busy%0d", i), {29'd0, hif.stallF_o, hif.stallE_o, hif.flushM_o}, 32'b111);
      end
      @(negedge clk); #1;
      check("wd_release",  {26'd0, ctl()}, 32'd0);
      check("wd_not_yet",  {31'd0, hif.mdu_timeout_o}, 32'd0);
      @(negedge clk); #1;
      check("wd_sticky1",  {31'd0, hif.mdu_timeout_o}, 32'd1);
      check("wd_run",      {26'd0, ctl()}, 32'd0);
      @(negedge clk); hif.mdu_startE_i = 1'b1; hif.mdu_done_i = 1'b1; #1;
      check("wd_sticky2",  {31'd0, hif.mdu_timeout_o}, 32'd1);

      // Asynchronous reset in the middle of BUSY.
      @(negedge clk); idle_inputs(); hif.mdu_startE_i = 1'b1; #1;
      @(negedge clk); hif.mdu_startE_i = 1'b0; #1;
      check("ar_busy",     {31'd0, hif.stallF_o}, 32'd1);
      #2 rst = 1'b1; #1;
      check("ar_ctl",      {26'd0, ctl()}, 32'b000_111);
      check("ar_timeout",  {31'd0, hif.mdu_timeout_o}, 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      check("ar_run",      {26'd0, ctl()}, 32'd0);

      // Perf: two load-use cycles plus one redirect.
      @(negedge clk); hif.loadE_i = 1'b1; hif.rdE_i = 5'd7; hif.rs2D_i = 5'd7; #1;
      @(negedge clk); #1;
      @(negedge clk); idle_inputs(); hif.pc_srcE_i = 1'b1; #1;
      @(negedge clk); idle_inputs(); #1;
`ifdef HAZARD_PERF_EN
      check("perf_stall",  hif.stall_cnt_o, 32'd2);
      check("perf_flush",  hif.flush_cnt_o, 32'd3);
`else
      check("perf_stall0", hif.stall_cnt_o, 32'd0);
      check("perf_flush0", hif.flush_cnt_o, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
